// File: rtl/differentiator.sv
// rtl/differentiator.sv - comb stage y[n] = x[n] - x[n-M] with overflow flags and optional saturation
// CLK_I is a slow strobe resynchronised onto MCLK_I; CLK_O is regenerated from the synchroniser tail.
module differentiator #(
  parameter int DATA_BIT_WIDTH = 5,
  parameter int DIFF_DELAY     = 1,
  parameter bit SATURATE       = 1'b1
) (
  input  logic                      MCLK_I,
  input  logic                      NRST_I,
  input  logic                      CLK_I,
  input  logic [DATA_BIT_WIDTH-1:0] DATA_I,
  output logic                      CLK_O,
  output logic [DATA_BIT_WIDTH-1:0] DATA_O,
  output logic                      OFDET_O,
  output logic                      UFDET_O
);
  localparam int N = DATA_BIT_WIDTH;
  localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  logic         s1_q, s2_q, s3_q;
  logic         clk_o_q;
  logic [N-1:0] hist_q [DIFF_DELAY];
  logic [N-1:0] hist_d [DIFF_DELAY];
  logic [N-1:0] data_q, data_d;
  logic         of_q, of_d;
  logic         uf_q, uf_d;
  logic         rise;
  logic [N:0]   diff;
  logic         ovf, unf;

  assign rise = s2_q & ~s3_q;
  assign diff = {DATA_I[N-1], DATA_I} - {hist_q[DIFF_DELAY-1][N-1], hist_q[DIFF_DELAY-1]};

  // The exact N+1-bit difference is out of N-bit range exactly when its top two bits disagree.
  assign ovf = ~diff[N] & diff[N-1];
  assign unf = diff[N] & ~diff[N-1];

  always_comb begin
    hist_d = hist_q;
    data_d = data_q;
    of_d   = of_q;
    uf_d   = uf_q;
    if (rise) begin
      hist_d[0] = DATA_I;
      for (int i = 1; i < DIFF_DELAY; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      of_d = ovf;
      uf_d = unf;
      if (SATURATE && ovf) begin
        data_d = MAX_VAL;
      end else if (SATURATE && unf) begin
        data_d = MIN_VAL;
      end else begin
        data_d = diff[N-1:0];
      end
    end
  end

  always_ff @(posedge MCLK_I) begin
    if (!NRST_I) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      clk_o_q <= 1'b0;
      data_q  <= '0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      for (int i = 0; i < DIFF_DELAY; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      s1_q    <= CLK_I;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      clk_o_q <= s3_q;
      data_q  <= data_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
      hist_q  <= hist_d;
    end
  end

  assign CLK_O   = clk_o_q;
  assign DATA_O  = data_q;
  assign OFDET_O = of_q;
  assign UFDET_O = uf_q;

endmodule

// File: tb/tb_differentiator.sv
// tb/tb_differentiator.sv - randomized self-checking bench for differentiator
// Four instances (saturate/wrap, M=1/2/4) share one stimulus and are checked against an arithmetic model.
module tb_differentiator;
  logic       MCLK_I = 1'b0;
  logic       NRST_I;
  logic       CLK_I;
  logic [4:0] DATA_I;

  logic       co_s1, co_w1, co_s2, co_w4;
  logic [4:0] do_s1, do_w1, do_s2, do_w4;
  logic       of_s1, of_w1, of_s2, of_w4;
  logic       uf_s1, uf_w1, uf_s2, uf_w4;

  int checks = 0;
  int errors = 0;
  int xs[$];

  always #1 MCLK_I = ~MCLK_I;

  differentiator #(.DATA_BIT_WIDTH(5), .DIFF_DELAY(1), .SATURATE(1'b1)) u_s1 (
    .MCLK_I(MCLK_I), .NRST_I(NRST_I), .CLK_I(CLK_I), .DATA_I(DATA_I),
    .CLK_O(co_s1), .DATA_O(do_s1), .OFDET_O(of_s1), .UFDET_O(uf_s1));
  differentiator #(.DATA_BIT_WIDTH(5), .DIFF_DELAY(1), .SATURATE(1'b0)) u_w1 (
    .MCLK_I(MCLK_I), .NRST_I(NRST_I), .CLK_I(CLK_I), .DATA_I(DATA_I),
    .CLK_O(co_w1), .DATA_O(do_w1), .OFDET_O(of_w1), .UFDET_O(uf_w1));
  differentiator #(.DATA_BIT_WIDTH(5), .DIFF_DELAY(2), .SATURATE(1'b1)) u_s2 (
    .MCLK_I(MCLK_I), .NRST_I(NRST_I), .CLK_I(CLK_I), .DATA_I(DATA_I),
    .CLK_O(co_s2), .DATA_O(do_s2), .OFDET_O(of_s2), .UFDET_O(uf_s2));
  differentiator #(.DATA_BIT_WIDTH(5), .DIFF_DELAY(4), .SATURATE(1'b0)) u_w4 (
    .MCLK_I(MCLK_I), .NRST_I(NRST_I), .CLK_I(CLK_I), .DATA_I(DATA_I),
    .CLK_O(co_w4), .DATA_O(do_w4), .OFDET_O(of_w4), .UFDET_O(uf_w4));

  logic [6:0] act [4];
  assign act[0] = {of_s1, uf_s1, do_s1};
  assign act[1] = {of_w1, uf_w1, do_w1};
  assign act[2] = {of_s2, uf_s2, do_s2};
  assign act[3] = {of_w4, uf_w4, do_w4};
  int mm [4] = '{1, 1, 2, 4};
  bit ss [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  function automatic int sx(input logic [4:0] v);
    return v[4] ? int'(v) - 32 : int'(v);
  endfunction

  // Expected {OFDET, UFDET, DATA} for the newest sample in xs, delay m, saturate sat.
  function automatic logic [6:0] model(input int m, input bit sat);
    int x, p, d;
    logic [31:0] dv;
    logic o, u;
    x = xs[xs.size()-1];
    p = (xs.size() > m) ? xs[xs.size()-1-m] : 0;
    d = x - p;
    o = (d > 15);
    u = (d < -16);
    if (sat && o) d = 15;
    else if (sat && u) d = -16;
    dv = d;
    return {o, u, dv[4:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge MCLK_I);
  endtask

  task automatic send(input logic [4:0] v);
    DATA_I = v;
    CLK_I  = 1'b0;
    cyc(32);
    CLK_I = 1'b1;
    xs.push_back(sx(v));
    cyc(32);
  endtask

  task automatic do_reset();
    CLK_I  = 1'b0;
    NRST_I = 1'b0;
    cyc(1);
    NRST_I = 1'b1;
    xs.delete();
  endtask

  task automatic test_reset();
    NRST_I = 1'b0;
    CLK_I  = 1'b0;
    DATA_I = 5'd0;
    cyc(1);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (act[j] !== 7'd0) begin
        errors++;
        $display("FAIL reset_out[%0d] got %h exp 00", j, act[j]);
      end
    end
    checks++;
    if ({co_s1, co_w1, co_s2, co_w4} !== 4'b0) begin
      errors++;
      $display("FAIL reset_clko got %b exp 0000", {co_s1, co_w1, co_s2, co_w4});
    end
    NRST_I = 1'b1;
    xs.delete();
  endtask

  task automatic test_step();
    logic [4:0] inp [5] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd3};
    logic [4:0] exp [5] = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    logic [4:0] prev = 5'd0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      DATA_I = inp[k];
      CLK_I  = 1'b0;
      cyc(32);
      CLK_I = 1'b1;
      cyc(2);
      checks++;
      if (do_s1 !== prev) begin
        errors++;
        $display("FAIL step_hold[%0d] got %h exp %h", k, do_s1, prev);
      end
      cyc(1);
      checks++;
      if (do_s1 !== exp[k]) begin
        errors++;
        $display("FAIL step_data[%0d] got %h exp %h", k, do_s1, exp[k]);
      end
      checks++;
      if (co_s1 !== 1'b0) begin
        errors++;
        $display("FAIL step_clko_early[%0d] got %b exp 0", k, co_s1);
      end
      cyc(1);
      checks++;
      if (co_s1 !== 1'b1) begin
        errors++;
        $display("FAIL step_clko_rise[%0d] got %b exp 1", k, co_s1);
      end
      cyc(28);
      prev = exp[k];
    end
  endtask

  task automatic test_integrator_ramp();
    logic [31:0] v;
    do_reset();
    for (int k = 0; k < 21; k++) begin
      v = -k;
      send(v[4:0]);
      if (k >= 1) begin
        checks++;
        if (do_w1 !== 5'h1f) begin
          errors++;
          $display("FAIL ramp_wrap_data[%0d] got %h exp 1f", k, do_w1);
        end
        checks++;
        if (of_w1 !== (k == 17)) begin
          errors++;
          $display("FAIL ramp_wrap_of[%0d] got %b exp %b", k, of_w1, (k == 17));
        end
        checks++;
        if ({of_s1, do_s1} !== ((k == 17) ? 6'h2f : 6'h1f)) begin
          errors++;
          $display("FAIL ramp_sat[%0d] got of=%b d=%h", k, of_s1, do_s1);
        end
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    send(5'h0f);
    send(5'h10);
    checks++;
    if ({uf_s1, of_s1, do_s1} !== 7'b10_10000) begin
      errors++;
      $display("FAIL uf_sat got uf=%b of=%b d=%h exp uf=1 of=0 d=10", uf_s1, of_s1, do_s1);
    end
    checks++;
    if ({uf_w1, of_w1, do_w1} !== 7'b10_00001) begin
      errors++;
      $display("FAIL uf_wrap got uf=%b of=%b d=%h exp uf=1 of=0 d=01", uf_w1, of_w1, do_w1);
    end
    send(5'h10);
    checks++;
    if ({uf_s1, of_s1, do_s1, uf_w1, of_w1, do_w1} !== 14'd0) begin
      errors++;
      $display("FAIL uf_clear got s=%b%b%h w=%b%b%h exp all 0", uf_s1, of_s1, do_s1, uf_w1, of_w1, do_w1);
    end
  endtask

  task automatic test_m2();
    logic [4:0] inp [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd3, 5'd3};
    logic [4:0] exp [6] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd1, 5'd0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      send(inp[k]);
      checks++;
      if (do_s2 !== exp[k]) begin
        errors++;
        $display("FAIL m2_data[%0d] got %h exp %h", k, do_s2, exp[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] last [4];
    logic [4:0] v;
    do_reset();
    for (int j = 0; j < 4; j++) last[j] = 7'd0;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 4))
        0: v = 5'h0f;
        1: v = 5'h10;
        default: v = 5'($urandom_range(0, 31));
      endcase
      DATA_I = v;
      CLK_I  = 1'b0;
      cyc(32);
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (act[j] !== last[j]) begin
          errors++;
          $display("FAIL rand_hold[%0d] dut %0d got %h exp %h", k, j, act[j], last[j]);
        end
      end
      CLK_I = 1'b1;
      xs.push_back(sx(v));
      cyc(32);
      for (int j = 0; j < 4; j++) begin
        last[j] = model(mm[j], ss[j]);
        checks++;
        if (act[j] !== last[j]) begin
          errors++;
          $display("FAIL rand_out[%0d] dut %0d got %h exp %h", k, j, act[j], last[j]);
        end
      end
    end
  endtask

  task automatic test_mid_reset_low();
    logic [6:0] e;
    do_reset();
    for (int k = 0; k < 10; k++) send(5'd7);
    do_reset();
    checks++;
    if ({co_s1, do_s1, of_s1, uf_s1} !== 8'd0) begin
      errors++;
      $display("FAIL midlo_clear got co=%b d=%h exp 0", co_s1, do_s1);
    end
    for (int k = 0; k < 2; k++) begin
      send(5'd4);
      checks++;
      if (do_s1 !== ((k == 0) ? 5'd4 : 5'd0)) begin
        errors++;
        $display("FAIL midlo_data[%0d] got %h exp %h", k, do_s1, (k == 0) ? 5'd4 : 5'd0);
      end
      e = model(4, 1'b0);
      checks++;
      if (act[3] !== e) begin
        errors++;
        $display("FAIL midlo_m4[%0d] got %h exp %h", k, act[3], e);
      end
    end
  endtask

  task automatic test_mid_reset_high();
    logic [6:0] e;
    do_reset();
    for (int k = 0; k < 3; k++) send(5'd7);
    DATA_I = 5'd9;
    CLK_I  = 1'b0;
    cyc(32);
    CLK_I = 1'b1;
    cyc(10);
    NRST_I = 1'b0;
    cyc(1);
    NRST_I = 1'b1;
    xs.delete();
    checks++;
    if ({co_s1, do_s1, of_s1, uf_s1, do_w4} !== 13'd0) begin
      errors++;
      $display("FAIL midhi_clear got co=%b d=%h d4=%h exp 0", co_s1, do_s1, do_w4);
    end
    cyc(2);
    checks++;
    if (do_s1 !== 5'd0) begin
      errors++;
      $display("FAIL midhi_early got %h exp 00", do_s1);
    end
    cyc(1);
    xs.push_back(9);
    checks++;
    if ({do_s1, do_w4} !== {5'd9, 5'd9}) begin
      errors++;
      $display("FAIL midhi_spurious got %h/%h exp 09/09", do_s1, do_w4);
    end
    DATA_I = 5'd3;
    cyc(20);
    checks++;
    if (do_s1 !== 5'd9) begin
      errors++;
      $display("FAIL midhi_single got %h exp 09", do_s1);
    end
    checks++;
    if ($isunknown({act[0], act[1], act[2], act[3], co_s1, co_w1, co_s2, co_w4})) begin
      errors++;
      $display("FAIL midhi_x got %h%h%h%h exp no X", act[0], act[1], act[2], act[3]);
    end
    send(5'd3);
    for (int j = 0; j < 4; j++) begin
      e = model(mm[j], ss[j]);
      checks++;
      if (act[j] !== e) begin
        errors++;
        $display("FAIL midhi_next dut %0d got %h exp %h", j, act[j], e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_integrator_ramp();
    test_underflow();
    test_m2();
    test_mid_reset_low();
    test_mid_reset_high();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
